// File: rtl/rr_handshake_arbiter_if.sv
// Ready/valid bundle between the requesting ports and the merged output channel.
// slave modport faces the arbiter; master modport faces whoever drives requests and consumes the output.
interface rr_handshake_arbiter_if #(
    parameter int N_PORTS    = 3,
    parameter int DATA_WIDTH = 4
);
    localparam int IDX_W = $clog2(N_PORTS);

    logic [N_PORTS-1:0]            in_valid;
    logic [N_PORTS-1:0]            in_ready;
    logic [N_PORTS*DATA_WIDTH-1:0] in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [IDX_W-1:0]              out_grant;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_grant
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_grant
    );
endinterface

// File: rtl/rr_handshake_arbiter.sv
// Round-robin merge of N ready/valid ports into one registered output stage.
// Define RR_HANDSHAKE_ARBITER_ASSERT_EN to compile the embedded protocol assertions.
module rr_handshake_arbiter #(
    parameter int N_PORTS    = 3,
    parameter int DATA_WIDTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    rr_handshake_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(N_PORTS);

    logic [IDX_W-1:0]      ptr_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [IDX_W-1:0]      out_grant_r;

    logic                  load_s;
    logic                  any_s;
    logic                  xfer_s;
    logic [IDX_W-1:0]      win_s;
    logic [N_PORTS-1:0]    in_ready_s;
    logic [DATA_WIDTH-1:0] win_data_s;

    // Scans ports starting at the priority pointer, wrapping modulo N_PORTS.
    function automatic logic [IDX_W-1:0] pick_winner(
        input logic [N_PORTS-1:0] req,
        input logic [IDX_W-1:0]   start
    );
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = start;
        found = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = (int'(start) + k) % N_PORTS;
            if (!found && req[idx]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign load_s = !out_valid_r || bus.out_ready;
    assign any_s  = |bus.in_valid;
    assign xfer_s = load_s && any_s && !RESET;
    assign win_s  = pick_winner(bus.in_valid, ptr_r);

    // Grant decode and winner payload select; only the winner may see ready.
    always_comb begin
        in_ready_s = {N_PORTS{1'b0}};
        win_data_s = bus.in_data[int'(win_s)*DATA_WIDTH +: DATA_WIDTH];
        if (xfer_s) begin
            in_ready_s[win_s] = 1'b1;
        end else begin
            in_ready_s = {N_PORTS{1'b0}};
        end
    end

    // Output register and priority pointer; pointer advances only on an accepted grant.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_grant_r <= {IDX_W{1'b0}};
            ptr_r       <= {IDX_W{1'b0}};
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= win_data_s;
            out_grant_r <= win_s;
            ptr_r       <= (win_s == IDX_W'(N_PORTS - 1)) ? {IDX_W{1'b0}} : win_s + IDX_W'(1);
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_grant = out_grant_r;

`ifdef RR_HANDSHAKE_ARBITER_ASSERT_EN
    a_ready_onehot0: assert property (@(posedge CLK) disable iff (RESET)
        $onehot0(bus.in_ready));

    a_out_hold: assert property (@(posedge CLK) disable iff (RESET)
        bus.out_valid && !bus.out_ready |=>
            $stable(bus.out_data) && $stable(bus.out_grant) && bus.out_valid);

    a_grant_range: assert property (@(posedge CLK) disable iff (RESET)
        int'(bus.out_grant) < N_PORTS);

    for (genvar i = 0; i < N_PORTS; i++) begin : g_in_stable
        a_in_stable: assert property (@(posedge CLK) disable iff (RESET)
            bus.in_valid[i] && !bus.in_ready[i] |=>
                bus.in_valid[i] && $stable(bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]));
    end
`endif
endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Directed bench for rr_handshake_arbiter: reset, round-robin order, backpressure,
// mid-operation reset, wrap-around priority and idle drain.
module tb_rr_handshake_arbiter;
    localparam int N  = 3;
    localparam int DW = 4;

    logic CLK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_bad = 0;

    rr_handshake_arbiter_if #(.N_PORTS(N), .DATA_WIDTH(DW)) bus_i ();

    rr_handshake_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_i)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic [2:0] exp);
        chk({tag, ".in_ready"}, 32'(bus_i.in_ready), 32'(exp));
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] g);
        chk({tag, ".out_valid"}, 32'(bus_i.out_valid), 32'(v));
        chk({tag, ".out_data"},  32'(bus_i.out_data),  32'(d));
        chk({tag, ".out_grant"}, 32'(bus_i.out_grant), 32'(g));
    endtask

    initial begin
        // Reset held two cycles with every port requesting
        RESET           = 1'b1;
        bus_i.in_valid  = 3'b111;
        bus_i.in_data   = 12'h321;
        bus_i.out_ready = 1'b1;
        #1;
        chk_rdy("rst_comb", 3'b000);
        tick();
        tick();
        chk_out("rst", 1'b0, 4'h0, 2'd0);
        chk_rdy("rst", 3'b000);

        // Round-robin with all ports valid
        RESET = 1'b0;
        #1;
        chk_rdy("rr_first", 3'b001);
        tick(); chk_out("rr0", 1'b1, 4'h1, 2'd0); chk_rdy("rr0", 3'b010);
        tick(); chk_out("rr1", 1'b1, 4'h2, 2'd1); chk_rdy("rr1", 3'b100);
        tick(); chk_out("rr2", 1'b1, 4'h3, 2'd2); chk_rdy("rr2", 3'b001);
        tick(); chk_out("rr3", 1'b1, 4'h1, 2'd0); chk_rdy("rr3", 3'b010);
        tick(); chk_out("rr4", 1'b1, 4'h2, 2'd1); chk_rdy("rr4", 3'b100);

        // Backpressure: load 0xA from port 2, then stall three cycles
        bus_i.in_data = 12'hA21;
        tick(); chk_out("bp_load", 1'b1, 4'hA, 2'd2);
        bus_i.out_ready = 1'b0;
        #1;
        chk_rdy("bp_stall", 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("bp_hold%0d", i), 1'b1, 4'hA, 2'd2);
            chk_rdy($sformatf("bp_hold%0d", i), 3'b000);
        end
        bus_i.out_ready = 1'b1;
        #1;
        chk_rdy("bp_release", 3'b001);
        tick(); chk_out("bp_poppush", 1'b1, 4'h1, 2'd0);

        // Reset mid-operation drops the held word and re-centres the pointer
        bus_i.out_ready = 1'b0;
        tick(); chk_out("mid_hold", 1'b1, 4'h1, 2'd0);
        RESET         = 1'b1;
        bus_i.in_data = 12'h321;
        #1;
        chk_rdy("mid_rst_comb", 3'b000);
        tick(); chk_out("mid_rst", 1'b0, 4'h0, 2'd0);
        RESET           = 1'b0;
        bus_i.out_ready = 1'b1;
        #1;
        chk_rdy("mid_ptr0", 3'b001);

        // Narrow requests down to port 2 only
        tick(); chk_out("nar0", 1'b1, 4'h1, 2'd0);
        bus_i.in_valid = 3'b110;
        #1;
        chk_rdy("nar0", 3'b010);
        tick(); chk_out("nar1", 1'b1, 4'h2, 2'd1);
        bus_i.in_valid = 3'b100;
        #1;
        chk_rdy("nar1", 3'b100);
        tick(); chk_out("p2_a", 1'b1, 4'h3, 2'd2); chk_rdy("p2_a", 3'b100);
        tick(); chk_out("p2_b", 1'b1, 4'h3, 2'd2); chk_rdy("p2_b", 3'b100);
        tick(); chk_out("p2_c", 1'b1, 4'h3, 2'd2);

        // No request with out_ready high drains valid, payload holds
        bus_i.in_valid = 3'b000;
        #1;
        chk_rdy("idle", 3'b000);
        tick(); chk_out("idle", 1'b0, 4'h3, 2'd2); chk_rdy("idle_after", 3'b000);

        // Pointer is 0 after port 2 wins; 011 serves 0, 1, then wraps past idle port 2
        bus_i.in_valid = 3'b011;
        bus_i.in_data  = 12'h354;
        #1;
        chk_rdy("wrap_start", 3'b001);
        tick(); chk_out("wrap0", 1'b1, 4'h4, 2'd0); chk_rdy("wrap0", 3'b010);
        tick(); chk_out("wrap1", 1'b1, 4'h5, 2'd1); chk_rdy("wrap1", 3'b001);
        tick(); chk_out("wrap2", 1'b1, 4'h4, 2'd0); chk_rdy("wrap2", 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
